// File: rtl/ls32_chk_pkg.sv
// Shared types and tables for the LS32 pattern checker.
// Holds FSM states, the OR-gate combo table and datapath widths.
package ls32_chk_pkg;

  localparam int N_GATES = 4;
  localparam int ERR_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_DONE
  } state_e;

  // Packed as {a, b}: c0=00, c1=10, c2=11, c3=01
  typedef struct packed {
    logic a;
    logic b;
  } combo_t;

  localparam combo_t COMBO [4] = '{
    2'b00, 2'b10, 2'b11, 2'b01
  };

  function automatic logic [1:0] cidx(
    input logic [1:0] v,
    input int         g
  );
    logic [1:0] gg;
    gg = g[1:0];
    return v + gg;
  endfunction

  function automatic logic [ERR_W-1:0] pop4(
    input logic [N_GATES-1:0] x
  );
    logic [ERR_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_GATES; i++) begin
      n = n + ERR_W'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ls32_vec_rom.sv
// Combinational map from vector index to the four A/B gate inputs.
// Gate g uses combo (v+g) mod 4.
module ls32_vec_rom
  import ls32_chk_pkg::*;
(
  input  logic [1:0]         v_i,
  output logic [N_GATES-1:0] a_o,
  output logic [N_GATES-1:0] b_o
);

  always_comb begin
    a_o = '0;
    b_o = '0;
    for (int g = 0; g < N_GATES; g++) begin
      a_o[g] = COMBO[cidx(v_i, g)].a;
      b_o[g] = COMBO[cidx(v_i, g)].b;
    end
  end

endmodule

// File: rtl/ls32_pattern_checker.sv
// Drives a rotating OR truth-table onto an LS32 and checks its outputs.
// Reports pass, mismatch count and sticky per-gate fail flags.
module ls32_pattern_checker
  import ls32_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [N_GATES-1:0] o_A,
  output logic [N_GATES-1:0] o_B,
  input  logic [N_GATES-1:0] i_Y,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [ERR_W-1:0]   o_err_cnt,
  output logic [N_GATES-1:0] o_fail_vec
);

  localparam logic [7:0] H_LAST = 8'(HOLD_CYCLES - 1);

  state_e             state_q;
  logic [1:0]         v_q;
  logic [7:0]         h_q;
  logic [N_GATES-1:0] a_q, b_q;
  logic               busy_q, done_q, pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [N_GATES-1:0] fail_q;

  logic [1:0]         v_d;
  logic [N_GATES-1:0] rom_a, rom_b;
  logic [N_GATES-1:0] mism_d;
  logic [ERR_W-1:0]   err_d;

  // ROM looks one vector ahead so the next pattern loads on the sample edge
  assign v_d    = (state_q == ST_APPLY) ? v_q + 2'd1 : 2'd0;
  assign mism_d = i_Y ^ (a_q | b_q);
  assign err_d  = err_q + pop4(mism_d);

  ls32_vec_rom u_rom (
    .v_i (v_d),
    .a_o (rom_a),
    .b_o (rom_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      h_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_APPLY;
            v_q     <= '0;
            h_q     <= '0;
            a_q     <= rom_a;
            b_q     <= rom_b;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
          end
        end
        ST_APPLY: begin
          if (h_q == H_LAST) begin
            h_q    <= '0;
            err_q  <= err_d;
            fail_q <= fail_q | mism_d;
            if (v_q == 2'd3) begin
              state_q <= ST_DONE;
              v_q     <= '0;
              a_q     <= '0;
              b_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              v_q <= v_q + 2'd1;
              a_q <= rom_a;
              b_q <= rom_b;
            end
          end else begin
            h_q <= h_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_err_cnt  = err_q;
  assign o_fail_vec = fail_q;

endmodule
